// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
package mem_stage_pkg;

  localparam int unsigned CONTROL_LINE     = 5;
  localparam int unsigned DATA_LEN         = 64;
  localparam int unsigned INSTRUCTION_PART = 5;

  localparam int unsigned CTL_REG_WRITE  = 4;
  localparam int unsigned CTL_MEM_TO_REG = 3;
  localparam int unsigned CTL_MEM_READ   = 2;
  localparam int unsigned CTL_MEM_WRITE  = 1;

  localparam logic [1:0] PRED_RESET = 2'b01;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic                        valid;
    logic                        reg_write;
    logic                        mem_to_reg;
    logic [DATA_LEN-1:0]         alu_val;
    logic [DATA_LEN-1:0]         mem_data;
    logic [INSTRUCTION_PART-1:0] rd;
  } mem_wb_t;

  typedef struct packed {
    logic                        we;
    logic                        reg_write;
    logic                        mem_to_reg;
    logic [DATA_LEN-1:0]         addr;
    logic [DATA_LEN-1:0]         wdata;
    logic [INSTRUCTION_PART-1:0] rd;
  } mem_op_t;

endpackage

// File: rtl/branch_predictor_2bit.sv
// Global 2-bit saturating branch predictor with a saturating mispredict counter.
module branch_predictor_2bit
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        resolve,
  input  logic        taken,
  input  logic        mispredict,
  output logic        predict_taken,
  output logic [31:0] mispredict_count
);

  logic [1:0]  ctr_q;
  logic [31:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr_q <= PRED_RESET;
      cnt_q <= '0;
    end else if (resolve) begin
      if (taken && ctr_q != 2'b11)
        ctr_q <= ctr_q + 2'b01;
      else if (!taken && ctr_q != 2'b00)
        ctr_q <= ctr_q - 2'b01;
      if (mispredict && cnt_q != 32'hFFFF_FFFF)
        cnt_q <= cnt_q + 32'd1;
    end
  end

  assign predict_taken    = ctr_q[1];
  assign mispredict_count = cnt_q;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: branch resolution, req/ack data-memory access, MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CONTROL_LINE-1:0]     control_in,
  input  logic                        if_beq_in,
  input  logic                        zero_in,
  input  logic                        predictor_in,
  input  logic [DATA_LEN-1:0]         alu_val_in,
  input  logic [DATA_LEN-1:0]         wr_addr_in,
  input  logic [INSTRUCTION_PART-1:0] instruction_part_in,
  output logic                        stall_out,
  output logic                        mem_flush,
  output logic                        predict_taken,
  output logic                        dmem_req,
  output logic                        dmem_we,
  output logic [DATA_LEN-1:0]         dmem_addr,
  output logic [DATA_LEN-1:0]         dmem_wdata,
  input  logic                        dmem_ack,
  input  logic [DATA_LEN-1:0]         dmem_rdata,
  output logic                        wb_valid,
  output logic                        wb_reg_write,
  output logic                        wb_mem_to_reg,
  output logic [DATA_LEN-1:0]         wb_alu_val,
  output logic [DATA_LEN-1:0]         wb_mem_data,
  output logic [INSTRUCTION_PART-1:0] wb_rd,
  output logic [31:0]                 mispredict_count
);

  state_t  state_q, state_d;
  mem_wb_t wb_q, wb_d;
  mem_op_t op_q;
  logic    op_load, mem_op, resolve;
  logic    unused_ctl;

  assign unused_ctl = control_in[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    wb_d      = wb_q;
    op_load   = 1'b0;
    stall_out = 1'b0;
    mem_flush = 1'b0;
    resolve   = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    mem_op    = control_in[CTL_MEM_READ] | control_in[CTL_MEM_WRITE];
    unique case (state_q)
      IDLE: begin
        if (mem_op) begin
          // memory access wins over a (malformed) branch in the same bundle
          state_d   = BUSY;
          op_load   = 1'b1;
          stall_out = 1'b1;
          wb_d      = '0;
        end else begin
          wb_d.valid      = (|control_in[CTL_REG_WRITE:CTL_MEM_WRITE]) | if_beq_in;
          wb_d.reg_write  = control_in[CTL_REG_WRITE];
          wb_d.mem_to_reg = control_in[CTL_MEM_TO_REG];
          wb_d.alu_val    = alu_val_in;
          wb_d.mem_data   = '0;
          wb_d.rd         = instruction_part_in;
          resolve         = if_beq_in;
          mem_flush       = if_beq_in & (zero_in ^ predictor_in);
        end
      end
      BUSY: begin
        dmem_req  = 1'b1;
        dmem_we   = op_q.we;
        stall_out = ~dmem_ack;
        wb_d      = '0;
        if (dmem_ack) begin
          state_d         = IDLE;
          wb_d.valid      = 1'b1;
          wb_d.reg_write  = op_q.reg_write;
          wb_d.mem_to_reg = op_q.mem_to_reg;
          wb_d.alu_val    = op_q.addr;
          wb_d.mem_data   = op_q.we ? '0 : dmem_rdata;
          wb_d.rd         = op_q.rd;
        end
      end
    endcase
    if (rst) begin
      stall_out = 1'b0;
      mem_flush = 1'b0;
      resolve   = 1'b0;
    end
  end

  // MEM/WB bundle and captured memory-op registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q <= '0;
      op_q <= '0;
    end else begin
      wb_q <= wb_d;
      if (op_load) begin
        op_q.we         <= control_in[CTL_MEM_WRITE];
        op_q.reg_write  <= control_in[CTL_REG_WRITE];
        op_q.mem_to_reg <= control_in[CTL_MEM_TO_REG];
        op_q.addr       <= alu_val_in;
        op_q.wdata      <= wr_addr_in;
        op_q.rd         <= instruction_part_in;
      end
    end
  end

  assign dmem_addr     = op_q.addr;
  assign dmem_wdata    = op_q.wdata;
  assign wb_valid      = wb_q.valid;
  assign wb_reg_write  = wb_q.reg_write;
  assign wb_mem_to_reg = wb_q.mem_to_reg;
  assign wb_alu_val    = wb_q.alu_val;
  assign wb_mem_data   = wb_q.mem_data;
  assign wb_rd         = wb_q.rd;

  branch_predictor_2bit u_bp (
    .clk              (clk),
    .rst              (rst),
    .resolve          (resolve),
    .taken            (zero_in),
    .mispredict       (mem_flush),
    .predict_taken    (predict_taken),
    .mispredict_count (mispredict_count)
  );

endmodule
